vga_clkgen_prog: RTL and testbench

- Sequencer for the VGA DCM_CLKGEN dynamic-reprogramming port inside the clock/reset generator.
- Takes a start pulse plus new M/D values from the VGA CSR bank and generates the PROGCLK/PROGEN/PROGDATA command stream: LoadD, LoadM, GO.
- Then waits for PROGDONE and for the DCM to relock, and reports done or error.
- Lives in the sys_clk domain, between the VGA CSR block and the CRG's vga_prog* ports.

---
 rtl/vga_clkgen_prog_pkg.sv | 34 +++
 rtl/vga_clkgen_prog_ser.sv | 75 +++++++
 rtl/vga_clkgen_prog.sv | 217 +++++++++++++++++++++
 tb/tb_vga_clkgen_prog.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_clkgen_prog_pkg.sv
// Shared definitions for the VGA DCM_CLKGEN reprogramming sequencer.
// Contents: FSM state type, command prefixes (bit0 is sent first), bit counts per
// phase, and err_code encodings.
package vga_clkgen_prog_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoadD,
      StGap1,
      StLoadM,
      StGap2,
      StGo,
      StWaitDone,
      StWaitLock
   } state_e;

   // Command prefixes: bit0 goes out first.
   localparam logic [1:0] LOADD_PFX = 2'b01;
   localparam logic [1:0] LOADM_PFX = 2'b11;

   localparam int unsigned LOAD_BITS = 10;
   localparam int unsigned GAP_BITS  = 2;
   localparam int unsigned GO_BITS   = 1;

   // Serializer word and bit-counter widths.
   localparam int unsigned WORD_W = 10;
   localparam int unsigned CNT_W  = 4;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BAD_M   = 2'd1;
   localparam logic [1:0] ERR_DONE_TO = 2'd2;
   localparam logic [1:0] ERR_LOCK_TO = 2'd3;

endpackage

// File: rtl/vga_clkgen_prog_ser.sv
// PROGCLK divider and 10-bit LSB-first shift register for the DCM program port.
// Ports:
//   clk, rst   sys_clk and asynchronous active-high reset
//   en         level; while low the divider is held with progclk low
//   load       strobe; loads word/len (bit0 of word becomes progdata at once)
//   word, len  next command word and its bit count
//   progclk    divided clock, starts low, toggles every PROG_HALF cycles
//   progdata   current serial bit (registered)
//   fall       high in the sys_clk cycle whose edge drops progclk
//   bit_last   the bit currently on progdata is the last of the word
module vga_clkgen_prog_ser
   import vga_clkgen_prog_pkg::*;
#(
   parameter int unsigned PROG_HALF = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [WORD_W-1:0] word,
   input  logic [CNT_W-1:0]  len,
   output logic              progclk,
   output logic              progdata,
   output logic              fall,
   output logic              bit_last
);

   localparam int unsigned HALF_W = (PROG_HALF > 1) ? $clog2(PROG_HALF) : 1;
   localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(PROG_HALF - 1);

   logic [HALF_W-1:0] half_cnt;
   logic              clk_q;
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  bits_left;
   logic              half_end;

   assign half_end = en && (half_cnt == HALF_MAX);
   assign fall     = half_end && clk_q;
   assign bit_last = (bits_left == CNT_W'(1));
   assign progclk  = clk_q;
   assign progdata = shreg[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_cnt <= '0;
         clk_q    <= 1'b0;
      end else if (!en) begin
         half_cnt <= '0;
         clk_q    <= 1'b0;
      end else if (half_end) begin
         half_cnt <= '0;
         clk_q    <= ~clk_q;
      end else begin
         half_cnt <= half_cnt + 1'b1;
      end
   end

   // Data only moves on load or on the progclk falling edge, so it is stable
   // for PROG_HALF cycles either side of every rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         bits_left <= '0;
      end else if (load) begin
         shreg     <= word;
         bits_left <= len;
      end else if (fall) begin
         shreg <= {1'b0, shreg[WORD_W-1:1]};
         if (bits_left != '0) begin
            bits_left <= bits_left - 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_clkgen_prog.sv
// Sequencer for the VGA DCM_CLKGEN dynamic reprogramming port.
// On start it sends LoadD, LoadM and GO, then waits for PROGDONE and relock.
// Ports:
//   sys_clk, sys_rst        clock and asynchronous active-high reset
//   start                   one-cycle request; m_minus1/d_minus1 sampled with it
//   busy                    sequence in progress
//   done, err               one-cycle completion / failure pulses
//   err_code                0 none, 1 bad M, 2 PROGDONE timeout, 3 lock timeout
//   locked_sync             vga_locked through a 2-FF synchronizer
//   vga_progclk/en/data     DCM program port outputs
//   vga_progdone, vga_locked DCM status inputs
module vga_clkgen_prog
   import vga_clkgen_prog_pkg::*;
#(
   parameter int unsigned PROG_HALF = 2,
   parameter int unsigned TIMEOUT   = 1048576,
   parameter int unsigned TO_W      = 21
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       start,
   input  logic [7:0] m_minus1,
   input  logic [7:0] d_minus1,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic       locked_sync,
   output logic       vga_progclk,
   output logic       vga_progen,
   output logic       vga_progdata,
   input  logic       vga_progdone,
   input  logic       vga_locked
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_e            state;
   logic [7:0]        m_q;
   logic [TO_W-1:0]   to_cnt;
   logic              lock_meta;

   logic              ser_en;
   logic              ser_load;
   logic [WORD_W-1:0] ser_word;
   logic [CNT_W-1:0]  ser_len;
   logic              ser_fall;
   logic              ser_last;

   logic              bit_end;
   logic              done_seen;
   logic              to_hit;
   logic              ending;

   assign bit_end   = ser_fall && ser_last;
   assign done_seen = ser_fall && vga_progdone;
   assign to_hit    = (to_cnt == TO_LAST);

   // Stopping the divider on the same edge the FSM returns to idle keeps
   // progclk low in every idle cycle. Timeout wins over a coincident PROGDONE
   // so this term does not depend on the divider it gates.
   assign ending = ((state == StWaitDone) && to_hit) ||
                   ((state == StWaitLock) && (locked_sync || to_hit));
   assign ser_en = (state != StIdle) && !ending;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         lock_meta   <= 1'b0;
         locked_sync <= 1'b0;
      end else begin
         lock_meta   <= vga_locked;
         locked_sync <= lock_meta;
      end
   end

   always_comb begin
      ser_load = 1'b0;
      ser_word = '0;
      ser_len  = '0;
      unique case (state)
         StIdle: begin
            if (start && (m_minus1 != 8'd0)) begin
               ser_load = 1'b1;
               ser_word = {d_minus1, LOADD_PFX};
               ser_len  = CNT_W'(LOAD_BITS);
            end
         end
         StLoadD, StLoadM: begin
            if (bit_end) begin
               ser_load = 1'b1;
               ser_len  = CNT_W'(GAP_BITS);
            end
         end
         StGap1: begin
            if (bit_end) begin
               ser_load = 1'b1;
               ser_word = {m_q, LOADM_PFX};
               ser_len  = CNT_W'(LOAD_BITS);
            end
         end
         StGap2: begin
            if (bit_end) begin
               ser_load = 1'b1;
               ser_len  = CNT_W'(GO_BITS);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= StIdle;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         vga_progen <= 1'b0;
         m_q        <= 8'd0;
         to_cnt     <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  if (m_minus1 == 8'd0) begin
                     err      <= 1'b1;
                     err_code <= ERR_BAD_M;
                  end else begin
                     m_q        <= m_minus1;
                     busy       <= 1'b1;
                     err_code   <= ERR_NONE;
                     vga_progen <= 1'b1;
                     state      <= StLoadD;
                  end
               end
            end
            StLoadD: begin
               if (bit_end) begin
                  vga_progen <= 1'b0;
                  state      <= StGap1;
               end
            end
            StGap1: begin
               if (bit_end) begin
                  vga_progen <= 1'b1;
                  state      <= StLoadM;
               end
            end
            StLoadM: begin
               if (bit_end) begin
                  vga_progen <= 1'b0;
                  state      <= StGap2;
               end
            end
            StGap2: begin
               if (bit_end) begin
                  vga_progen <= 1'b1;
                  state      <= StGo;
               end
            end
            StGo: begin
               if (bit_end) begin
                  vga_progen <= 1'b0;
                  to_cnt     <= '0;
                  state      <= StWaitDone;
               end
            end
            StWaitDone: begin
               if (to_hit) begin
                  err      <= 1'b1;
                  err_code <= ERR_DONE_TO;
                  busy     <= 1'b0;
                  state    <= StIdle;
               end else if (done_seen) begin
                  to_cnt <= '0;
                  state  <= StWaitLock;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            StWaitLock: begin
               if (locked_sync) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (to_hit) begin
                  err      <= 1'b1;
                  err_code <= ERR_LOCK_TO;
                  busy     <= 1'b0;
                  state    <= StIdle;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   vga_clkgen_prog_ser #(
      .PROG_HALF(PROG_HALF)
   ) u_ser (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .en       (ser_en),
      .load     (ser_load),
      .word     (ser_word),
      .len      (ser_len),
      .progclk  (vga_progclk),
      .progdata (vga_progdata),
      .fall     (ser_fall),
      .bit_last (ser_last)
   );

endmodule

// File: tb/tb_vga_clkgen_prog.sv
// Directed bench for vga_clkgen_prog. One instance (TIMEOUT=1024) runs the normal
// sequences; a second (TIMEOUT=64) runs the timeout scenarios. Both share reset,
// M/D, progdone and locked; each has its own start.
module tb_vga_clkgen_prog;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       start;
   logic       start_to;
   logic [7:0] m_minus1;
   logic [7:0] d_minus1;
   logic       vga_progdone;
   logic       vga_locked;

   logic       busy, done, err, locked_sync, vga_progclk, vga_progen, vga_progdata;
   logic [1:0] err_code;
   logic       busy_b, done_b, err_b, locked_sync_b, progclk_b, progen_b, progdata_b;
   logic [1:0] err_code_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 sys_clk = ~sys_clk;

   vga_clkgen_prog #(
      .PROG_HALF(2),
      .TIMEOUT  (1024),
      .TO_W     (21)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .start        (start),
      .m_minus1     (m_minus1),
      .d_minus1     (d_minus1),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .err_code     (err_code),
      .locked_sync  (locked_sync),
      .vga_progclk  (vga_progclk),
      .vga_progen   (vga_progen),
      .vga_progdata (vga_progdata),
      .vga_progdone (vga_progdone),
      .vga_locked   (vga_locked)
   );

   vga_clkgen_prog #(
      .PROG_HALF(2),
      .TIMEOUT  (64),
      .TO_W     (21)
   ) dut_to (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .start        (start_to),
      .m_minus1     (m_minus1),
      .d_minus1     (d_minus1),
      .busy         (busy_b),
      .done         (done_b),
      .err          (err_b),
      .err_code     (err_code_b),
      .locked_sync  (locked_sync_b),
      .vga_progclk  (progclk_b),
      .vga_progen   (progen_b),
      .vga_progdata (progdata_b),
      .vga_progdone (vga_progdone),
      .vga_locked   (vga_locked)
   );

   // Record progen/progdata at every progclk rising edge of dut, plus the
   // sys_clk spacing between rising edges.
   logic en_q[$];
   logic dat_q[$];
   int   gap_q[$];
   logic clk_prev  = 1'b0;
   int   cyc       = 0;
   int   last_rise = 0;
   int   done_cnt  = 0;
   int   err_cnt   = 0;

   always @(negedge sys_clk) begin
      cyc      <= cyc + 1;
      clk_prev <= vga_progclk;
      if (vga_progclk && !clk_prev) begin
         en_q.push_back(vga_progen);
         dat_q.push_back(vga_progdata);
         gap_q.push_back(cyc - last_rise);
         last_rise <= cyc;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         #1;
      end
   endtask

   task automatic pulse_start(input int which, input logic [7:0] m, input logic [7:0] d);
      m_minus1 = m;
      d_minus1 = d;
      if (which == 0) start = 1'b1;
      else start_to = 1'b1;
      tick(1);
      start    = 1'b0;
      start_to = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst      = 1'b1;
      start        = 1'b0;
      start_to     = 1'b0;
      m_minus1     = 8'd0;
      d_minus1     = 8'd0;
      vga_progdone = 1'b0;
      vga_locked   = 1'b1;
      tick(3);
      n_checks++;
      if ({busy, done, err, err_code, locked_sync, vga_progclk, vga_progen, vga_progdata}
          !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, want 000000000",
                  {busy, done, err, err_code, locked_sync, vga_progclk, vga_progen,
                   vga_progdata});
      end
      n_checks++;
      if ({busy_b, done_b, err_b, err_code_b, locked_sync_b, progclk_b, progen_b, progdata_b}
          !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_to: got %b, want 000000000",
                  {busy_b, done_b, err_b, err_code_b, locked_sync_b, progclk_b, progen_b,
                   progdata_b});
      end
      sys_rst = 1'b0;
      tick(1);
      n_checks++;
      if (locked_sync !== 1'b0) begin
         n_fail++;
         $display("FAIL sync_stage1: locked_sync=%b, want 0", locked_sync);
      end
      tick(1);
      n_checks++;
      if (locked_sync !== 1'b1) begin
         n_fail++;
         $display("FAIL sync_stage2: locked_sync=%b, want 1", locked_sync);
      end
      vga_locked = 1'b0;
      tick(2);
      n_checks++;
      if (locked_sync !== 1'b0) begin
         n_fail++;
         $display("FAIL sync_fall: locked_sync=%b, want 0", locked_sync);
      end
   endtask

   // mode 0: plain sequence; mode 1: a second start arrives mid-LoadM.
   task automatic test_sequence(input string name, input int mode);
      int          base;
      int          dbase;
      int          ebase;
      int          waited;
      int          bad_gaps;
      int          sz;
      logic [0:24] exp_en;
      logic [0:24] exp_dat;
      exp_en  = 25'b1111111111_00_1111111111_00_1;
      exp_dat = 25'b1000011000_00_1100110000_00_0;
      vga_progdone = 1'b0;
      vga_locked   = 1'b0;
      base  = en_q.size();
      dbase = done_cnt;
      ebase = err_cnt;
      pulse_start(0, 8'h0C, 8'h18);
      n_checks++;
      if (busy !== 1'b1 || err_code !== 2'd0) begin
         n_fail++;
         $display("FAIL %s capture: busy=%b err_code=%0d, want busy=1 err_code=0",
                  name, busy, err_code);
      end
      if (mode == 1) begin
         waited = 0;
         while (en_q.size() < base + 15 && waited < 200) begin
            tick(1);
            waited++;
         end
         pulse_start(0, 8'h55, 8'h33);
      end
      // DCM model: PROGDONE three progclk periods after GO.
      waited = 0;
      while (en_q.size() < base + 28 && waited < 400) begin
         tick(1);
         waited++;
      end
      n_checks++;
      if (en_q.size() < base + 28) begin
         n_fail++;
         $display("FAIL %s progclk_edges: got %0d, want 28", name, en_q.size() - base);
      end
      vga_progdone = 1'b1;
      waited = 0;
      while (en_q.size() < base + 29 && waited < 20) begin
         tick(1);
         waited++;
      end
      vga_progdone = 1'b0;
      tick(100);
      vga_locked = 1'b1;
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
         tick(1);
         waited++;
      end
      n_checks++;
      if (waited !== 3) begin
         n_fail++;
         $display("FAIL %s done_latency: got %0d cycles, want 3", name, waited);
      end
      n_checks++;
      if ({busy, err, vga_progclk, vga_progen} !== 4'b0000) begin
         n_fail++;
         $display("FAIL %s at_done: busy,err,progclk,progen=%b, want 0000",
                  name, {busy, err, vga_progclk, vga_progen});
      end
      tick(1);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_pulse: done=%b one cycle later, want 0", name, done);
      end
      for (int i = 0; i < 25; i++) begin
         n_checks++;
         if (base + i >= en_q.size()) begin
            n_fail++;
            $display("FAIL %s bit%0d: missing, want en=%b data=%b",
                     name, i, exp_en[i], exp_dat[i]);
         end else if ({en_q[base+i], dat_q[base+i]} !== {exp_en[i], exp_dat[i]}) begin
            n_fail++;
            $display("FAIL %s bit%0d: got en=%b data=%b, want en=%b data=%b", name, i,
                     en_q[base+i], dat_q[base+i], exp_en[i], exp_dat[i]);
         end
      end
      bad_gaps = 0;
      for (int i = 1; i < 25; i++) begin
         if (base + i < gap_q.size() && gap_q[base+i] != 4) bad_gaps++;
      end
      n_checks++;
      if (bad_gaps !== 0) begin
         n_fail++;
         $display("FAIL %s bit_period: %0d periods not 4 cycles, want 0", name, bad_gaps);
      end
      n_checks++;
      if (base + 25 >= en_q.size() || en_q[base+25] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s wait_progen: missing or high after GO, want 0", name);
      end
      n_checks++;
      if (done_cnt - dbase !== 1 || err_cnt - ebase !== 0) begin
         n_fail++;
         $display("FAIL %s pulse_counts: done=%0d err=%0d, want done=1 err=0",
                  name, done_cnt - dbase, err_cnt - ebase);
      end
      sz = en_q.size();
      tick(8);
      n_checks++;
      if (en_q.size() !== sz || vga_progclk !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle_progclk: %0d new edges progclk=%b, want 0 edges low",
                  name, en_q.size() - sz, vga_progclk);
      end
   endtask

   task automatic test_bad_m();
      int base;
      int ebase;
      base  = en_q.size();
      ebase = err_cnt;
      pulse_start(0, 8'h00, 8'h18);
      n_checks++;
      if ({err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL bad_m_pulse: err,err_code,busy=%b, want 1010", {err, err_code, busy});
      end
      tick(1);
      n_checks++;
      if ({err, err_code, busy} !== {1'b0, 2'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL bad_m_hold: err,err_code,busy=%b, want 0010", {err, err_code, busy});
      end
      tick(20);
      n_checks++;
      if (en_q.size() !== base || vga_progclk !== 1'b0 || vga_progen !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_m_pins: %0d edges progclk=%b progen=%b, want 0 edges, 0, 0",
                  en_q.size() - base, vga_progclk, vga_progen);
      end
      n_checks++;
      if (err_cnt - ebase !== 1) begin
         n_fail++;
         $display("FAIL bad_m_count: %0d err pulses, want 1", err_cnt - ebase);
      end
   endtask

   task automatic test_progdone_timeout();
      int waited;
      vga_progdone = 1'b0;
      vga_locked   = 1'b0;
      pulse_start(1, 8'h0C, 8'h18);
      n_checks++;
      if (busy_b !== 1'b1) begin
         n_fail++;
         $display("FAIL done_to_busy: busy=%b, want 1", busy_b);
      end
      waited = 0;
      while (err_b !== 1'b1 && waited < 400) begin
         tick(1);
         waited++;
      end
      // 25 bits * 4 cycles, then TIMEOUT=64 cycles in WAIT_DONE.
      n_checks++;
      if (waited !== 164) begin
         n_fail++;
         $display("FAIL done_to_latency: got %0d cycles, want 164", waited);
      end
      n_checks++;
      if ({err_code_b, busy_b, progen_b, progclk_b, done_b} !== {2'd2, 4'b0000}) begin
         n_fail++;
         $display("FAIL done_to_state: err_code=%0d busy,progen,progclk,done=%b, want 2 0000",
                  err_code_b, {busy_b, progen_b, progclk_b, done_b});
      end
      tick(1);
      n_checks++;
      if (err_b !== 1'b0 || err_code_b !== 2'd2) begin
         n_fail++;
         $display("FAIL done_to_hold: err=%b err_code=%0d, want 0 2", err_b, err_code_b);
      end
   endtask

   task automatic test_lock_timeout();
      int waited;
      vga_progdone = 1'b1;
      vga_locked   = 1'b0;
      pulse_start(1, 8'h0C, 8'h18);
      waited = 0;
      while (err_b !== 1'b1 && waited < 400) begin
         tick(1);
         waited++;
      end
      // WAIT_DONE exits on the first progclk fall (+4), then 64 cycles.
      n_checks++;
      if (waited !== 168) begin
         n_fail++;
         $display("FAIL lock_to_latency: got %0d cycles, want 168", waited);
      end
      n_checks++;
      if (err_code_b !== 2'd3 || busy_b !== 1'b0 || done_b !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_to_state: err_code=%0d busy=%b done=%b, want 3 0 0",
                  err_code_b, busy_b, done_b);
      end
      vga_progdone = 1'b0;
      tick(3);
      n_checks++;
      if (err_code_b !== 2'd3) begin
         n_fail++;
         $display("FAIL lock_to_hold: err_code=%0d, want 3", err_code_b);
      end
      pulse_start(1, 8'h0C, 8'h18);
      n_checks++;
      if (err_code_b !== 2'd0 || busy_b !== 1'b1) begin
         n_fail++;
         $display("FAIL err_code_clear: err_code=%0d busy=%b, want 0 1", err_code_b, busy_b);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      int waited;
      vga_progdone = 1'b0;
      vga_locked   = 1'b1;
      tick(3);
      n_checks++;
      if (locked_sync !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre: locked_sync=%b, want 1", locked_sync);
      end
      base = en_q.size();
      pulse_start(0, 8'h0C, 8'h18);
      waited = 0;
      while (en_q.size() < base + 6 && waited < 100) begin
         tick(1);
         waited++;
      end
      n_checks++;
      if (en_q.size() < base + 6) begin
         n_fail++;
         $display("FAIL reset_mid_reach: got %0d edges, want 6", en_q.size() - base);
      end
      // Mid-cycle, away from any clock edge.
      sys_rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, err, err_code, locked_sync, vga_progclk, vga_progen, vga_progdata}
          !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got %b, want 000000000",
                  {busy, done, err, err_code, locked_sync, vga_progclk, vga_progen,
                   vga_progdata});
      end
      tick(2);
      sys_rst    = 1'b0;
      vga_locked = 1'b0;
      tick(2);
      test_sequence("after_reset", 0);
   endtask

   initial begin
      test_reset();
      test_sequence("basic", 0);
      test_bad_m();
      test_progdone_timeout();
      test_lock_timeout();
      test_sequence("ignore_start", 1);
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
